// File: rtl/core_pkg.sv
// Shared definitions for the PC sequencer: word widths, the fetch FSM state
// encoding and the default reset/exception addresses.
package core_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [WORD_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_EXC_VECTOR = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect arbiter: picks the highest-priority control-flow
// source, forms its target address and flags simultaneous redirects.
module pc_target_mux
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [WORD_W-1:0] i_pc_seq,
  input  logic              i_exc_en,
  input  logic              i_jr_en,
  input  logic [WORD_W-1:0] i_jr_target,
  input  logic              i_jal_en,
  input  logic [JIDX_W-1:0] i_jal_index,
  input  logic              i_jump_en,
  input  logic [JIDX_W-1:0] i_jump_index,
  input  logic              i_branch_en,
  input  logic [WORD_W-1:0] i_branch_offset,
  output logic              o_redirect,
  output logic [WORD_W-1:0] o_target,
  output logic              o_conflict
);

  logic [2:0] w_cnt;

  // Priority: exception > jr > jal > jump > branch.
  always_comb begin
    o_redirect = 1'b1;
    o_target   = i_pc_seq;
    if (i_exc_en) begin
      o_target = EXC_VECTOR;
    end else if (i_jr_en) begin
      o_target = i_jr_target;
    end else if (i_jal_en) begin
      o_target = {i_pc_seq[WORD_W-1:JIDX_W], i_jal_index};
    end else if (i_jump_en) begin
      o_target = {i_pc_seq[WORD_W-1:JIDX_W], i_jump_index};
    end else if (i_branch_en) begin
      o_target = i_pc_seq + i_branch_offset;
    end else begin
      o_redirect = 1'b0;
    end
  end

  assign w_cnt = {2'b00, i_jr_en} + {2'b00, i_jal_en} + {2'b00, i_jump_en} + {2'b00, i_branch_en};
  assign o_conflict = (w_cnt >= 3'd2);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner and instruction fetch sequencer (req/ack to imem,
// valid/ready to decode). Optional exception entry: PC_SEQ_EXC_VECTOR_EN.
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              dec_ready,
  input  logic              jr_en,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              jal_en,
  input  logic [JIDX_W-1:0] jal_index,
  input  logic              jump_en,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_en,
  input  logic [WORD_W-1:0] branch_offset,
  input  logic              stall,
`ifdef PC_SEQ_EXC_VECTOR_EN
  input  logic              exc_en,
  output logic [WORD_W-1:0] epc,
`endif
  output logic              redirect_conflict
);

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_pc, r_addr, r_instr, r_instr_pc;
  logic              r_req, r_kill, r_valid, r_conflict;
  logic [WORD_W-1:0] w_pc_nxt, w_addr_nxt, w_pc_seq, w_target;
  logic              w_req_nxt, w_kill_nxt, w_valid_nxt, w_capture;
  logic              w_redirect, w_conflict, w_exc;

`ifdef PC_SEQ_EXC_VECTOR_EN
  logic [WORD_W-1:0] r_epc;
  assign w_exc = exc_en;
  assign epc   = r_epc;
`else
  assign w_exc = 1'b0;
`endif

  assign w_pc_seq = r_instr_pc + 32'd1;

  pc_target_mux #(.EXC_VECTOR(EXC_VECTOR)) u_mux (
    .i_pc_seq       (w_pc_seq),
    .i_exc_en       (w_exc),
    .i_jr_en        (jr_en),
    .i_jr_target    (jr_target),
    .i_jal_en       (jal_en),
    .i_jal_index    (jal_index),
    .i_jump_en      (jump_en),
    .i_jump_index   (jump_index),
    .i_branch_en    (branch_en),
    .i_branch_offset(branch_offset),
    .o_redirect     (w_redirect),
    .o_target       (w_target),
    .o_conflict     (w_conflict)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_REQ;
      ST_REQ:     if (r_req && imem_ack && !r_kill && !w_redirect) w_state_nxt = ST_DELIVER;
                  else w_state_nxt = ST_REQ;
      ST_DELIVER: if (w_redirect || dec_ready) w_state_nxt = ST_REQ;
                  else w_state_nxt = ST_DELIVER;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // A redirect against an outstanding request marks it killed; the response
  // is then dropped and a fresh request to the new pc is launched.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_kill_nxt  = r_kill;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_nxt  = !stall;
        w_addr_nxt = r_pc;
      end
      ST_REQ: begin
        if (r_req) begin
          if (imem_ack) begin
            w_req_nxt  = 1'b0;
            w_kill_nxt = 1'b0;
            if (w_redirect) begin
              w_pc_nxt = w_target;
            end else if (!r_kill) begin
              w_capture   = 1'b1;
              w_valid_nxt = 1'b1;
            end else begin
              w_pc_nxt = r_pc;
            end
          end else if (w_redirect) begin
            w_pc_nxt   = w_target;
            w_kill_nxt = 1'b1;
          end else begin
            w_kill_nxt = r_kill;
          end
        end else begin
          w_pc_nxt   = w_redirect ? w_target : r_pc;
          w_req_nxt  = !stall;
          w_addr_nxt = w_pc_nxt;
        end
      end
      ST_DELIVER: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else if (dec_ready) begin
          w_pc_nxt    = r_pc + 32'd1;
          w_valid_nxt = 1'b0;
        end else begin
          w_valid_nxt = 1'b1;
        end
        w_req_nxt  = (w_redirect || dec_ready) && !stall;
        w_addr_nxt = w_pc_nxt;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_addr     <= 32'h0000_0000;
      r_req      <= 1'b0;
      r_kill     <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
      r_conflict <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
      r_kill     <= w_kill_nxt;
      r_valid    <= w_valid_nxt;
      r_conflict <= w_conflict;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_addr;
      end
    end
  end

`ifdef PC_SEQ_EXC_VECTOR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_epc <= 32'h0000_0000;
    else if (w_exc && (r_state != ST_IDLE)) r_epc <= r_instr_pc;
  end
`endif

  assign imem_req          = r_req;
  assign imem_addr         = r_addr;
  assign instr_valid       = r_valid;
  assign instr             = r_instr;
  assign instr_pc          = r_instr_pc;
  assign redirect_conflict = r_conflict;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build) with a
// simple instruction-memory responder whose ack delay is adjustable.
module tb_pc_sequencer;

  logic        clock, reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, dec_ready;
  logic [31:0] instr, instr_pc;
  logic        jr_en, jal_en, jump_en, branch_en, stall, redirect_conflict;
  logic [31:0] jr_target, branch_offset;
  logic [25:0] jal_index, jump_index;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int age = 0;
  int ack_delay = 1;
  bit mem_auto = 1'b1;
  bit fired;
  logic [31:0] f_pc, f_ins;

  pc_sequencer dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .dec_ready(dec_ready),
    .jr_en(jr_en), .jr_target(jr_target), .jal_en(jal_en), .jal_index(jal_index),
    .jump_en(jump_en), .jump_index(jump_index), .branch_en(branch_en), .branch_offset(branch_offset),
    .stall(stall), .redirect_conflict(redirect_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; records a decode handshake taken at this edge, then drives memory.
  task automatic tick();
    fired = instr_valid && dec_ready && !(jr_en || jal_en || jump_en || branch_en);
    f_pc  = instr_pc;
    f_ins = instr;
    @(posedge clock);
    #1;
    cyc++;
    if (imem_ack) begin
      imem_ack = 1'b0;
    end else if (mem_auto && imem_req) begin
      age++;
      if (age > ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        age        = 0;
      end
    end else begin
      age = 0;
    end
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 30; i++) begin
      if (instr_valid) break;
      tick();
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: instr_valid timeout got %b expected 1", name, instr_valid);
    end
  endtask

  task automatic wait_deliver(input string name);
    int i;
    bit got;
    got = 1'b0;
    for (i = 0; i < 30; i++) begin
      tick();
      if (fired) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: delivery timeout got 0 expected 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
    checks++; if (redirect_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict: got %b expected 0", redirect_conflict); end
    #2 reset = 1'b0;
  endtask

  task automatic test_sequential();
    int rise, val;
    rise = -1;
    val  = -1;
    dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req && rise < 0) rise = cyc;
      if (instr_valid) begin
        val = cyc;
        break;
      end
    end
    checks++;
    if (val - rise !== 2) begin errors++; $display("FAIL latency: got %0d expected 2", val - rise); end
    for (int k = 0; k < 4; k++) begin
      wait_deliver("seq");
      checks++;
      if (f_pc !== k) begin errors++; $display("FAIL seq_pc: got %h expected %h", f_pc, k); end
      checks++;
      if (f_ins !== (k ^ KEY)) begin errors++; $display("FAIL seq_instr: got %h expected %h", f_ins, k ^ KEY); end
    end
  endtask

  task automatic test_branch();
    wait_deliver("br_pre");
    checks++; if (f_pc !== 32'd4) begin errors++; $display("FAIL br_pre_pc: got %h expected 4", f_pc); end
    dec_ready = 1'b0;
    wait_valid("br_valid");
    checks++; if (instr_pc !== 32'd5) begin errors++; $display("FAIL br_at5: got %h expected 5", instr_pc); end
    branch_en = 1'b1; branch_offset = 32'hFFFF_FFFD; dec_ready = 1'b1;
    tick();
    branch_en = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_squash: got %b expected 0", instr_valid); end
    wait_deliver("br_tgt");
    checks++; if (f_pc !== 32'd3) begin errors++; $display("FAIL br_tgt_pc: got %h expected 3", f_pc); end
  endtask

  task automatic test_jump_kill();
    logic [31:0] old_addr;
    ack_delay = 3;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      tick();
    end
    old_addr = imem_addr;
    jump_en = 1'b1; jump_index = 26'h000_0040;
    tick();
    jump_en = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL jmp_hold_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL jmp_addr_stable: got %h expected %h", imem_addr, 32'd4); end
    wait_deliver("jmp");
    checks++; if (f_pc !== 32'h0000_0040) begin errors++; $display("FAIL jmp_pc: got %h expected 00000040 (old %h)", f_pc, old_addr); end
    checks++; if (f_ins !== (32'h0000_0040 ^ KEY)) begin errors++; $display("FAIL jmp_instr: got %h expected %h", f_ins, 32'h40 ^ KEY); end
    ack_delay = 1;
  endtask

  task automatic test_conflict();
    dec_ready = 1'b0;
    wait_valid("cf_valid");
    checks++; if (instr_pc !== 32'h41) begin errors++; $display("FAIL cf_pre: got %h expected 41", instr_pc); end
    jr_en = 1'b1; jr_target = 32'h100; jump_en = 1'b1; jump_index = 26'h200;
    tick();
    jr_en = 1'b0; jump_en = 1'b0;
    checks++; if (redirect_conflict !== 1'b1) begin errors++; $display("FAIL cf_pulse: got %b expected 1", redirect_conflict); end
    tick();
    checks++; if (redirect_conflict !== 1'b0) begin errors++; $display("FAIL cf_once: got %b expected 0", redirect_conflict); end
    dec_ready = 1'b1;
    wait_deliver("cf");
    checks++; if (f_pc !== 32'h100) begin errors++; $display("FAIL cf_pc: got %h expected 100", f_pc); end
  endtask

  task automatic test_wrap();
    dec_ready = 1'b0;
    wait_valid("wr_v0");
    jr_en = 1'b1; jr_target = 32'hFFFF_FFEF;
    tick();
    jr_en = 1'b0;
    wait_valid("wr_v1");
    checks++; if (instr_pc !== 32'hFFFF_FFEF) begin errors++; $display("FAIL wr_jr: got %h expected ffffffef", instr_pc); end
    branch_en = 1'b1; branch_offset = 32'h7FFF_FFFF;
    tick();
    branch_en = 1'b0;
    dec_ready = 1'b1;
    wait_deliver("wr");
    checks++; if (f_pc !== 32'h7FFF_FFEF) begin errors++; $display("FAIL wr_pc: got %h expected 7fffffef", f_pc); end
    checks++; if (f_ins !== 32'hDA5A_5A4A) begin errors++; $display("FAIL wr_instr: got %h expected da5a5a4a", f_ins); end
  endtask

  task automatic test_stall();
    dec_ready = 1'b0;
    wait_valid("st_v");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr_pc !== 32'h7FFF_FFF0) begin errors++; $display("FAIL st_pc: got %h expected 7ffffff0", instr_pc); end
      checks++; if (instr !== (32'h7FFF_FFF0 ^ KEY)) begin errors++; $display("FAIL st_instr: got %h expected %h", instr, 32'h7FFF_FFF0 ^ KEY); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req: got %b expected 0", imem_req); end
    end
    stall = 1'b0; dec_ready = 1'b1;
    wait_deliver("st_d0");
    checks++; if (f_pc !== 32'h7FFF_FFF0) begin errors++; $display("FAIL st_d0: got %h expected 7ffffff0", f_pc); end
    wait_deliver("st_d1");
    checks++; if (f_pc !== 32'h7FFF_FFF1) begin errors++; $display("FAIL st_d1: got %h expected 7ffffff1", f_pc); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      tick();
    end
    mem_auto = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", imem_req); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rm_pc: got %h expected 0", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    #2 reset = 1'b0;
    imem_ack = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", imem_addr); end
    age = 0; mem_auto = 1'b1;
    wait_deliver("rm");
    checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL rm_restart_pc: got %h expected 0", f_pc); end
    checks++; if (f_ins !== KEY) begin errors++; $display("FAIL rm_restart_instr: got %h expected %h", f_ins, KEY); end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b0;
    jr_en = 1'b0; jr_target = 32'h0; jal_en = 1'b0; jal_index = 26'h0;
    jump_en = 1'b0; jump_index = 26'h0; branch_en = 1'b0; branch_offset = 32'h0; stall = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_kill();
    test_conflict();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the architectural PC of the core and sequences instruction fetch. It arbitrates between control-flow redirect sources (JR, JAL, Jump, Branch) and sequential flow, issues a req/ack fetch to instruction memory, and hands fetched words to decode with a valid/ready handshake. It sits between the decode/execute control logic and instruction memory. PC is word-addressed: sequential step is +1.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
EXC_VECTOR, 32'h0000_0020, exception entry address (used only with EXC_VECTOR_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch word address, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction
instr_valid  out  1  instr/instr_pc valid for decode
instr  out  32  instruction to decode
instr_pc  out  32  address of instr
dec_ready  in  1  decode accepts when instr_valid and dec_ready are both 1
jr_en  in  1  one-cycle redirect pulse, target = jr_target
jr_target  in  32  absolute word address
jal_en  in  1  redirect pulse, target = {pc_seq[31:26], jal_index}
jal_index  in  26  JAL index field
jump_en  in  1  redirect pulse, target = {pc_seq[31:26], jump_index}
jump_index  in  26  J index field
branch_en  in  1  taken-branch pulse, target = pc_seq + branch_offset
branch_offset  in  32  signed word offset, sign-extended by producer
stall  in  1  freeze: no new fetch request is launched
redirect_conflict  out  1  one-cycle pulse when more than one redirect is asserted in the same cycle

Behaviour:
- pc_seq = PC of the last instruction delivered to decode, plus 1; 32-bit wrap, no overflow flag. Branch add is modulo 2^32.
- Reset (async): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, redirect_conflict=0, kill=0.
- FSM:
  IDLE -> REQ on the first clock after reset deasserts.
  REQ: imem_req=1, imem_addr=pc. If stall=1 on entry, hold imem_req=0 in REQ until stall=0. Once raised, imem_req stays high until imem_ack, regardless of stall.
  REQ + imem_ack -> if kill=0, latch instr=imem_rdata, instr_pc=pc, instr_valid=1, go to DELIVER; if kill=1, clear kill and stay in REQ with the new pc.
  DELIVER: hold outputs until dec_ready=1. On handshake: instr_valid=0, pc=pc+1 (unless a redirect applies), go to REQ.
- Redirect priority: jr > jal > jump > branch > sequential. Only the winner is applied. If more than one is asserted, redirect_conflict pulses for one cycle.
- Redirect in REQ with the request outstanding (imem_req=1, no ack): pc=target, kill=1. The pending response is discarded, and a new request to the target follows ack. If ack arrives in the same cycle as the redirect, that word is discarded and the next request uses the target.
- Redirect in REQ with no request outstanding: pc=target, no kill.
- Redirect in DELIVER: instr_valid drops next cycle (the word is squashed even if dec_ready=1 in the same cycle), pc=target, go to REQ.
- Fetch latency: minimum 2 cycles from imem_req rise to instr_valid (ack in the cycle after req, data registered).
- Reset mid-transfer: all state clears and any outstanding ack is ignored until the next REQ.

Optional Feature:
Macro PC_SEQ_EXC_VECTOR_EN.
- Enabled: adds input exc_en (1) and output epc (32, reset 0).
- exc_en has priority over every redirect: pc=EXC_VECTOR, epc=instr_pc of the current or last delivered instruction, in-flight fetch killed.
- Disabled: these ports are absent and EXC_VECTOR is unused.

Decomposition:
- Shared package (core_pkg): FSM state enum (IDLE/REQ/DELIVER), WORD_W=32, JIDX_W=26, default RESET_PC/EXC_VECTOR constants.
- One natural sub-module, pc_target_mux: combinational priority select and target arithmetic plus the conflict flag. The sequencer keeps all registers and the FSM.

Test Plan:
- Reset, then ack every request one cycle later with rdata=addr^32'hA5A5_A5A5, dec_ready=1 -> instr_pc sequence 0,1,2,3; instr matches; first instr_valid 2 cycles after imem_req rises.
- At instr_pc=5, pulse branch_en with offset=-3 -> next instr_pc=3. Offset 32'h7FFF_FFFF from pc_seq 32'hFFFF_FFF0 -> wraps to 32'h7FFF_FFEF.
- jump_en with index 26'h000_0040 while a request is outstanding and ack is delayed 3 cycles -> stale word never reaches decode; next instr_pc=32'h0000_0040.
- jr_en with jr_target=32'h100, plus jump_en, in the same cycle -> instr_pc=32'h100 and redirect_conflict=1 for exactly one cycle.
- dec_ready=0 for 4 cycles in DELIVER with stall=1 -> instr/instr_pc stable, imem_req=0. Release both -> exactly one delivery, no duplicate.
- Assert reset asynchronously while imem_req=1 -> outputs clear the same cycle; fetch restarts at RESET_PC; a late ack is ignored.
